alu_op_decoder: RTL and testbench

Registered instruction-to-ALU-control decoder. It is the producing end of the ALU's `ALUOp` interface. It accepts 32-bit RV32I instruction words over a valid/ready handshake and emits the 4-bit `ALUOp` the ALU consumes, plus operand-select and illegal flags, one cycle later. A 2-entry skid buffer keeps `in_ready` registered so the block can sit between fetch and execute in the multicycle/pipelined variants of the core.

---
 rtl/alu_pkg.sv | 42 ++++
 rtl/alu_op_decoder_if.sv | 25 ++
 rtl/alu_op_decode_comb.sv | 80 ++++++++
 rtl/alu_op_decoder.sv | 88 ++++++++
 tb/tb_alu_op_decoder.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control types: the 4-bit ALUOp codes (also used by the ALU),
// RV32I major opcodes, the decoded control bundle and skid-buffer states.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SLL    = 4'b0001,
    ALU_SLT    = 4'b0010,
    ALU_SLTU   = 4'b0011,
    ALU_XOR    = 4'b0100,
    ALU_SRL    = 4'b0101,
    ALU_OR     = 4'b0110,
    ALU_AND    = 4'b0111,
    ALU_SUB    = 4'b1000,
    ALU_PASS_B = 4'b1001,
    ALU_SRA    = 4'b1101
  } alu_op_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    alu_op_e op;
    logic    src_a_pc;
    logic    src_b_imm;
    logic    illegal;
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/alu_op_decoder_if.sv
// Instruction-in / ALU-control-out handshake bundle of the ALUOp decoder.
// slave: the decoder's view; master: the fetch/execute side driving it.
interface alu_op_decoder_if;
  import alu_pkg::*;

  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  alu_op_e     alu_op;
  logic        alu_src_a_pc;
  logic        alu_src_b_imm;
  logic        illegal;

  modport slave (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid, alu_op, alu_src_a_pc, alu_src_b_imm, illegal
  );

  modport master (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid, alu_op, alu_src_a_pc, alu_src_b_imm, illegal
  );
endinterface

// File: rtl/alu_op_decode_comb.sv
// Pure combinational RV32I instruction -> ALU control decode.
// Any undecodable word yields illegal=1 with ADD and both source flags clear.
module alu_op_decode_comb
  import alu_pkg::*;
(
  input  logic [31:0] i_instr,
  output alu_ctrl_t   o_ctrl
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic       w_unused_bits;
  alu_ctrl_t  w_ctrl;

  assign w_opcode = i_instr[6:0];
  assign w_funct3 = i_instr[14:12];
  assign w_funct7 = i_instr[31:25];
  // Register/immediate fields play no part in choosing the ALU operation.
  assign w_unused_bits = ^{i_instr[24:15], i_instr[11:7]};

  // Opcode/funct decode, then force a clean ADD/no-source encoding when illegal.
  always_comb begin
    w_ctrl = '{op: ALU_ADD, src_a_pc: 1'b0, src_b_imm: 1'b0, illegal: 1'b0};
    // The opcode constants include instr[1:0]=11, so compressed words fall to default.
    case (w_opcode)
      OP_R: begin
        w_ctrl.op      = alu_op_e'({w_funct7[5], w_funct3});
        w_ctrl.illegal = !((w_funct7 == 7'b0000000) ||
                           ((w_funct7 == 7'b0100000) &&
                            ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))));
      end
      OP_IMM: begin
        w_ctrl.src_b_imm = 1'b1;
        case (w_funct3)
          3'b000: w_ctrl.op = ALU_ADD;
          3'b001: begin
            w_ctrl.op      = ALU_SLL;
            w_ctrl.illegal = (w_funct7 != 7'b0000000);
          end
          3'b101: begin
            w_ctrl.op      = alu_op_e'({w_funct7[5], 3'b101});
            w_ctrl.illegal = !((w_funct7 == 7'b0000000) || (w_funct7 == 7'b0100000));
          end
          default: w_ctrl.op = alu_op_e'({1'b0, w_funct3});
        endcase
      end
      OP_LOAD, OP_STORE: w_ctrl.src_b_imm = 1'b1;
      OP_BRANCH: begin
        case (w_funct3)
          3'b000, 3'b001: w_ctrl.op = ALU_SUB;
          3'b100, 3'b101: w_ctrl.op = ALU_SLT;
          3'b110, 3'b111: w_ctrl.op = ALU_SLTU;
          default:        w_ctrl.illegal = 1'b1;
        endcase
      end
      OP_LUI: begin
        w_ctrl.op        = ALU_PASS_B;
        w_ctrl.src_b_imm = 1'b1;
      end
      OP_AUIPC, OP_JAL: begin
        w_ctrl.src_a_pc  = 1'b1;
        w_ctrl.src_b_imm = 1'b1;
      end
      OP_JALR: begin
        w_ctrl.src_b_imm = 1'b1;
        w_ctrl.illegal   = (w_funct3 != 3'b000);
      end
      default: w_ctrl.illegal = 1'b1;
    endcase

    o_ctrl = w_ctrl;
    if (w_ctrl.illegal) begin
      o_ctrl.op        = ALU_ADD;
      o_ctrl.src_a_pc  = 1'b0;
      o_ctrl.src_b_imm = 1'b0;
    end
  end

endmodule

// File: rtl/alu_op_decoder.sv
// Registered instruction -> ALUOp decoder with a 2-entry skid buffer.
// in_ready comes straight from a register so fetch never sees a
// combinational path from the downstream out_ready.
module alu_op_decoder
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  alu_op_decoder_if.slave bus
);

  alu_ctrl_t   w_dec;
  logic        w_accept;
  logic        w_pop;

  skid_state_e r_state;
  alu_ctrl_t   r_main;
  alu_ctrl_t   r_skid;
  logic        r_in_ready;
  logic        r_out_valid;

  alu_op_decode_comb u_decode (
    .i_instr (bus.instr),
    .o_ctrl  (w_dec)
  );

  assign w_accept = bus.in_valid && r_in_ready;
  assign w_pop    = r_out_valid && bus.out_ready;

  // Skid-buffer FSM: main feeds the outputs, skid catches the one entry
  // that arrives while the output is stalled; flush beats accept and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_state     <= ST_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_main      <= w_dec;
            r_out_valid <= 1'b1;
            r_state     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_pop) begin
            r_main <= w_dec;
          end else if (w_accept) begin
            r_skid     <= w_dec;
            r_in_ready <= 1'b0;
            r_state    <= ST_FULL;
          end else if (w_pop) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_pop) begin
            r_main     <= r_skid;
            r_in_ready <= 1'b1;
            r_state    <= ST_ONE;
          end
        end
        default: begin
          r_state     <= ST_EMPTY;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready      = r_in_ready;
  assign bus.out_valid     = r_out_valid;
  assign bus.alu_op        = r_main.op;
  assign bus.alu_src_a_pc  = r_main.src_a_pc;
  assign bus.alu_src_b_imm = r_main.src_b_imm;
  assign bus.illegal       = r_main.illegal;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed bench for alu_op_decoder: inputs driven and outputs checked on the
// falling edge; each check is an immediate assertion.
module tb_alu_op_decoder;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  logic flush;
  int   n_pass;
  int   n_total;

  alu_op_decoder_if bus ();

  alu_op_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present one word with out_ready already high, then check its decode a cycle later.
  task automatic dec_one(input string tag, input logic [31:0] word, input logic [3:0] e_op,
                         input logic e_a, input logic e_b, input logic e_ill);
    bus.in_valid = 1'b1;
    bus.instr    = word;
    step();
    $display("txn %s instr=%08h op=%04b a=%0b b=%0b ill=%0b", tag, word,
             bus.alu_op, bus.alu_src_a_pc, bus.alu_src_b_imm, bus.illegal);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_op"}, 32'(bus.alu_op), 32'(e_op));
    check({tag, "_a"}, 32'(bus.alu_src_a_pc), 32'(e_a));
    check({tag, "_b"}, 32'(bus.alu_src_b_imm), 32'(e_b));
    check({tag, "_ill"}, 32'(bus.illegal), 32'(e_ill));
  endtask

  initial begin
    n_pass        = 0;
    n_total       = 0;
    rst_n         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.instr     = 32'h0;
    bus.out_ready = 1'b0;
    step();
    step();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_op", 32'(bus.alu_op), 32'h0);
    check("rst_flags", 32'({bus.alu_src_a_pc, bus.alu_src_b_imm, bus.illegal}), 32'h0);
    rst_n = 1'b1;
    step();
    check("idle_out_valid", 32'(bus.out_valid), 32'd0);

    // Single SUB
    bus.out_ready = 1'b1;
    dec_one("sub", 32'h40208033, 4'b1000, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    step();
    check("sub_drain", 32'(bus.out_valid), 32'd0);

    // Back-to-back stream, no bubbles
    dec_one("srai", 32'h4030D093, 4'b1101, 1'b0, 1'b1, 1'b0);
    dec_one("lui", 32'h123450B7, 4'b1001, 1'b0, 1'b1, 1'b0);
    dec_one("bltu", 32'h0020E463, 4'b0011, 1'b0, 1'b0, 1'b0);
    check("stream_in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b0;
    step();
    check("stream_drain", 32'(bus.out_valid), 32'd0);

    // Backpressure: AND and ADDI accepted, AUIPC refused
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.instr     = 32'h0020F0B3;
    step();
    check("bp1_valid", 32'(bus.out_valid), 32'd1);
    check("bp1_op", 32'(bus.alu_op), 32'h7);
    check("bp1_in_ready", 32'(bus.in_ready), 32'd1);
    bus.instr = 32'h00100093;
    step();
    check("bp2_in_ready", 32'(bus.in_ready), 32'd0);
    check("bp2_op_held", 32'(bus.alu_op), 32'h7);
    bus.instr = 32'h00000097;
    step();
    check("bp3_in_ready", 32'(bus.in_ready), 32'd0);
    check("bp3_op_held", 32'(bus.alu_op), 32'h7);
    check("bp3_b_held", 32'(bus.alu_src_b_imm), 32'd0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    $display("txn bp_release op=%04b b=%0b in_ready=%0b", bus.alu_op, bus.alu_src_b_imm, bus.in_ready);
    check("bp_second_valid", 32'(bus.out_valid), 32'd1);
    check("bp_second_op", 32'(bus.alu_op), 32'h0);
    check("bp_second_b", 32'(bus.alu_src_b_imm), 32'd1);
    check("bp_second_a", 32'(bus.alu_src_a_pc), 32'd0);
    check("bp_in_ready_back", 32'(bus.in_ready), 32'd1);
    step();
    check("bp_no_third", 32'(bus.out_valid), 32'd0);

    // Illegal words and remaining opcode classes
    dec_one("zero", 32'h00000000, 4'b0000, 1'b0, 1'b0, 1'b1);
    dec_one("mul", 32'h0200F033, 4'b0000, 1'b0, 1'b0, 1'b1);
    dec_one("br010", 32'h0000A063, 4'b0000, 1'b0, 1'b0, 1'b1);
    dec_one("jalr_f3", 32'h000010E7, 4'b0000, 1'b0, 1'b0, 1'b1);
    dec_one("slli_f7", 32'h40009093, 4'b0000, 1'b0, 1'b0, 1'b1);
    dec_one("auipc", 32'h00000097, 4'b0000, 1'b1, 1'b1, 1'b0);
    dec_one("jal", 32'h0000006F, 4'b0000, 1'b1, 1'b1, 1'b0);
    dec_one("lw", 32'h00002083, 4'b0000, 1'b0, 1'b1, 1'b0);
    dec_one("sra", 32'h4020D0B3, 4'b1101, 1'b0, 1'b0, 1'b0);
    dec_one("bge", 32'h0020D463, 4'b0010, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    step();

    // Flush while FULL with in_valid high
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.instr     = 32'h40208033;
    step();
    bus.instr = 32'h4030D093;
    step();
    check("fl_full", 32'(bus.in_ready), 32'd0);
    flush     = 1'b1;
    bus.instr = 32'h123450B7;
    step();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    $display("txn flush_full out_valid=%0b in_ready=%0b", bus.out_valid, bus.in_ready);
    check("fl_out_valid", 32'(bus.out_valid), 32'd0);
    check("fl_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    step();
    check("fl_nothing", 32'(bus.out_valid), 32'd0);

    // Flush in ONE: the word accepted in the flush cycle is discarded
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.instr     = 32'h40208033;
    step();
    flush     = 1'b1;
    bus.instr = 32'h123450B7;
    step();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    check("fl1_out_valid", 32'(bus.out_valid), 32'd0);
    check("fl1_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    step();
    check("fl1_nothing", 32'(bus.out_valid), 32'd0);

    // Asynchronous reset mid-stream while FULL
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.instr     = 32'h123450B7;
    step();
    bus.instr = 32'h0020F0B3;
    step();
    check("ar_pre_full", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    $display("txn async_reset out_valid=%0b in_ready=%0b op=%04b", bus.out_valid, bus.in_ready, bus.alu_op);
    check("ar_out_valid", 32'(bus.out_valid), 32'd0);
    check("ar_in_ready", 32'(bus.in_ready), 32'd1);
    check("ar_op", 32'(bus.alu_op), 32'h0);
    check("ar_flags", 32'({bus.alu_src_a_pc, bus.alu_src_b_imm, bus.illegal}), 32'h0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("ar_idle", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b1;
    dec_one("post_rst", 32'h4030D093, 4'b1101, 1'b0, 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    step();
    check("post_rst_drain", 32'(bus.out_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
